uart_cmd_frame_tx: RTL and testbench
====================================

Name: uart_cmd_frame_tx

Overview:
- Host-side command serializer that sits directly upstream of the system's RX_IN pin.
- Accepts one decoded command request per handshake and expands it into the system's command byte sequence (command code, then operands).
- Transmits each byte as a UART frame (start, 8 data bits LSB first, optional parity, stop) on a single serial line.
- Used both as a board-level host stub and as the stimulus driver for system-level regression.

Parameters:
- CLKS_PER_BIT, 8, CLK cycles each serial bit is held; legal range 2..255.
- IDLE_BITS, 1, extra idle-high bit periods inserted after each stop bit; legal range 0..3.
- DW, 8, data byte width; fixed at 8 for the current system.

Ports:
- CLK  in  1  single clock; all state changes on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request valid.
- cmd_ready  out  1  block can accept a command.
- cmd_type  in  2  00 = reg write, 01 = reg read, 10 = ALU with operands, 11 = ALU no operand.
- cmd_addr  in  8  register address (write/read).
- cmd_data  in  8  write data.
- cmd_op_a  in  8  ALU operand A.
- cmd_op_b  in  8  ALU operand B.
- cmd_fun  in  8  ALU function byte.
- par_en  in  1  parity enable.
- par_type  in  1  0 = even parity, 1 = odd parity.
- TX_LINE  out  1  serial output; idle high.
- busy  out  1  high while a command is in progress.
- done  out  1  one-cycle pulse when a command's last bit slot ends.

Behaviour:
- Reset values: TX_LINE=1, cmd_ready=1, busy=0, done=0. FSM=IDLE, all counters=0.
- Reset mid-frame aborts immediately. TX_LINE returns to 1 asynchronously. No partial completion, no done pulse.
- Accept: on a rising edge with cmd_valid=1 and cmd_ready=1.
  - cmd_type, all operand fields, par_en and par_type are captured into holding registers.
  - Inputs are ignored until the next accept; configuration changes mid-command have no effect.
- cmd_ready = (state==IDLE). busy = ~cmd_ready.
- Byte sequence per cmd_type:
  - 00: 0xAA, addr, data (3 bytes).
  - 01: 0xBB, addr (2 bytes).
  - 10: 0xCC, A, B, fun (4 bytes).
  - 11: 0xDD, fun (2 bytes).
- FSM states: IDLE -> START -> DATA -> (PARITY if par_en) -> STOP -> (GAP if IDLE_BITS>0) -> START for the next byte, or IDLE after the last byte.
- Bit slots:
  - Each state holds TX_LINE for exactly CLKS_PER_BIT cycles (tick counter 0..CLKS_PER_BIT-1, wraps on each bit).
  - DATA covers 8 slots, bit index 0..7, LSB first.
  - GAP lasts IDLE_BITS slots with TX_LINE=1.
- Timing:
  - TX_LINE drops to 0 in the first cycle after the accept edge.
  - Bytes follow back-to-back with no dead cycles beyond GAP.
- Parity bit:
  - Even: XOR of the 8 data bits.
  - Odd: inverted XOR of the 8 data bits.
- Slot length S = (10 + par_en + IDLE_BITS) × CLKS_PER_BIT cycles per byte.
- done:
  - Asserts in cycle N×S after the accept edge (N = byte count).
  - In that same cycle the state is IDLE, so cmd_ready=1.
  - A new command accepted on that edge starts its start bit the next cycle, giving zero-gap chaining.
- cmd_valid held while busy: no effect and no queuing; the command is accepted only once cmd_ready=1.
- Byte counter width is 2 bits; it must not wrap beyond the byte count for cmd_type.

Test Plan:
- Reset, then idle for 50 cycles -> TX_LINE=1, cmd_ready=1, done=0 throughout.
- CLKS_PER_BIT=8, IDLE_BITS=1, par_en=0, cmd_type=00, addr=0x05, data=0x3C.
  - Line decodes to bytes 0xAA, 0x05, 0x3C; each start bit lasts 8 cycles.
  - done pulses exactly 264 cycles after accept; cmd_ready=0 for cycles 1..263.
- par_en=1, par_type=0, cmd_type=11, fun=0x07.
  - Bytes 0xDD (parity 0) and 0x07 (parity 1).
  - done at 2×96=192 cycles.
  - Repeat with par_type=1 -> parity bits 1 and 0.
- cmd_type=10, A=0x12, B=0x34, fun=0x00, with cmd_valid held high continuously and a second command (cmd_type=01, addr=0x02) presented.
  - 4 bytes are sent, then 0xBB, 0x02 start the cycle after done.
  - No duplicate accept of the first command.
- After accept, toggle par_en, cmd_addr and cmd_data every cycle -> transmitted bytes and parity match the values captured at accept.
- Assert RST during DATA bit 3 of byte 2 -> TX_LINE=1 within the same cycle.
  - No done pulse; cmd_ready=1 after release.
  - A subsequent command transmits correctly from its start bit.

Source files
------------

// File: rtl/uart_cmd_frame_tx_if.sv
// Command request bundle between a host and the UART command serializer.
// The host drives the request fields and the serializer returns cmd_ready.
interface uart_cmd_frame_tx_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_type;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_data;
  logic [7:0] cmd_op_a;
  logic [7:0] cmd_op_b;
  logic [7:0] cmd_fun;
  logic       par_en;
  logic       par_type;

  modport master (
    output cmd_valid, cmd_type, cmd_addr, cmd_data, cmd_op_a, cmd_op_b,
           cmd_fun, par_en, par_type,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_type, cmd_addr, cmd_data, cmd_op_a, cmd_op_b,
           cmd_fun, par_en, par_type,
    output cmd_ready
  );
endinterface

// File: rtl/uart_cmd_frame_tx.sv
// Host-side command serializer: expands one accepted command into its byte
// sequence and sends each byte as a UART frame (start, 8 data LSB first,
// optional parity, stop, IDLE_BITS idle-high bits) on TX_LINE.
// The final cycle of the last slot is spent in IDLE so that a new command
// accepted together with the done pulse chains with no gap on the line.
module uart_cmd_frame_tx #(
  parameter int CLKS_PER_BIT = 8,
  parameter int IDLE_BITS    = 1,
  parameter int DW           = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  uart_cmd_frame_tx_if.slave   cmd,
  output logic                 TX_LINE,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_GAP
  } state_t;

  localparam logic [7:0] TICK_LAST = 8'(CLKS_PER_BIT - 1);
  localparam logic [7:0] TICK_PRE  = 8'(CLKS_PER_BIT - 2);
  localparam logic       HAS_GAP   = 1'(IDLE_BITS > 0);
  localparam logic [2:0] GAP_LAST  = 3'((IDLE_BITS > 0) ? (IDLE_BITS - 1) : 0);

  state_t          state_q, state_d;
  logic [7:0]      tick_q, tick_d;
  logic [2:0]      bit_q, bit_d;
  logic [1:0]      byte_q, byte_d;
  logic [1:0]      type_q, type_d;
  logic [DW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   data_q, data_d;
  logic [DW-1:0]   op_a_q, op_a_d;
  logic [DW-1:0]   op_b_q, op_b_d;
  logic [DW-1:0]   fun_q, fun_d;
  logic            pe_q, pe_d;
  logic            pt_q, pt_d;
  logic            tx_q, tx_d;
  logic            done_q, done_d;

  logic            slot_end_s;
  logic            last_byte_s;
  logic            final_slot_s;
  logic [DW-1:0]   cur_byte_s;

  // Byte idx of the sequence for a given command type.
  function automatic logic [DW-1:0] byte_sel(
    input logic [1:0] typ, input logic [1:0] idx,
    input logic [DW-1:0] addr, input logic [DW-1:0] data,
    input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] fun);
    logic [DW-1:0] r;
    r = 8'hFF;
    case (typ)
      2'b00: begin
        case (idx)
          2'd0:    r = 8'hAA;
          2'd1:    r = addr;
          default: r = data;
        endcase
      end
      2'b01:   r = (idx == 2'd0) ? 8'hBB : addr;
      2'b10: begin
        case (idx)
          2'd0:    r = 8'hCC;
          2'd1:    r = a;
          2'd2:    r = b;
          default: r = fun;
        endcase
      end
      default: r = (idx == 2'd0) ? 8'hDD : fun;
    endcase
    return r;
  endfunction

  // Index of the last byte for a command type.
  function automatic logic [1:0] last_idx(input logic [1:0] typ);
    logic [1:0] r;
    case (typ)
      2'b00:   r = 2'd2;
      2'b10:   r = 2'd3;
      default: r = 2'd1;
    endcase
    return r;
  endfunction

  // Even parity is the XOR of the data bits; odd parity inverts it.
  function automatic logic parity_bit(input logic [DW-1:0] b, input logic odd);
    return (^b) ^ odd;
  endfunction

  assign slot_end_s   = (tick_q == TICK_LAST);
  assign last_byte_s  = (byte_q == last_idx(type_q));
  assign final_slot_s = last_byte_s &&
                        (HAS_GAP ? ((state_q == S_GAP) && (bit_q == GAP_LAST))
                                 : (state_q == S_STOP));

  // Next-state, counters, capture and next line level.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    type_d  = type_q;
    addr_d  = addr_q;
    data_d  = data_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    fun_d   = fun_q;
    pe_d    = pe_q;
    pt_d    = pt_q;
    done_d  = 1'b0;
    tx_d    = 1'b1;

    if (state_q == S_IDLE) begin
      if (cmd.cmd_valid) begin
        type_d  = cmd.cmd_type;
        addr_d  = cmd.cmd_addr;
        data_d  = cmd.cmd_data;
        op_a_d  = cmd.cmd_op_a;
        op_b_d  = cmd.cmd_op_b;
        fun_d   = cmd.cmd_fun;
        pe_d    = cmd.par_en;
        pt_d    = cmd.par_type;
        state_d = S_START;
        tick_d  = 8'd0;
        bit_d   = 3'd0;
        byte_d  = 2'd0;
      end else begin
        state_d = S_IDLE;
      end
    end else if (final_slot_s && (tick_q == TICK_PRE)) begin
      // Last cycle of the command is spent idle (line high) with done.
      state_d = S_IDLE;
      tick_d  = 8'd0;
      bit_d   = 3'd0;
      byte_d  = 2'd0;
      done_d  = 1'b1;
    end else if (!slot_end_s) begin
      tick_d = tick_q + 8'd1;
    end else begin
      tick_d = 8'd0;
      case (state_q)
        S_START: begin
          state_d = S_DATA;
          bit_d   = 3'd0;
        end
        S_DATA: begin
          if (bit_q == 3'd7) begin
            bit_d   = 3'd0;
            state_d = pe_q ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
        S_PARITY: state_d = S_STOP;
        S_STOP: begin
          if (HAS_GAP) begin
            state_d = S_GAP;
            bit_d   = 3'd0;
          end else begin
            state_d = S_START;
            byte_d  = byte_q + 2'd1;
          end
        end
        S_GAP: begin
          if (bit_q == GAP_LAST) begin
            state_d = S_START;
            bit_d   = 3'd0;
            byte_d  = byte_q + 2'd1;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    cur_byte_s = byte_sel(type_q, byte_d, addr_q, data_q, op_a_q, op_b_q, fun_q);
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = cur_byte_s[bit_d];
      S_PARITY: tx_d = parity_bit(cur_byte_s, pt_q);
      default:  tx_d = 1'b1;
    endcase
  end

  // State, counters, holding registers and registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      tick_q  <= 8'd0;
      bit_q   <= 3'd0;
      byte_q  <= 2'd0;
      type_q  <= 2'd0;
      addr_q  <= '0;
      data_q  <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      fun_q   <= '0;
      pe_q    <= 1'b0;
      pt_q    <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      type_q  <= type_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      fun_q   <= fun_d;
      pe_q    <= pe_d;
      pt_q    <= pt_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  assign cmd.cmd_ready = (state_q == S_IDLE);
  assign busy          = (state_q != S_IDLE);
  assign TX_LINE       = tx_q;
  assign done          = done_q;

endmodule

// File: tb/tb_uart_cmd_frame_tx.sv
// Directed bench for uart_cmd_frame_tx: a table of commands with hand-computed
// bytes, parity bits and done cycle, plus chaining, mid-command input changes
// and reset-abort sequences.
module tb_uart_cmd_frame_tx;
  localparam int CPB = 8;
  localparam int IB  = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx, busy, done;

  always #5 clk = ~clk;

  uart_cmd_frame_tx_if bus ();

  uart_cmd_frame_tx #(.CLKS_PER_BIT(CPB), .IDLE_BITS(IB), .DW(8)) dut (
    .CLK     (clk),
    .RST     (rst),
    .cmd     (bus),
    .TX_LINE (tx),
    .busy    (busy),
    .done    (done)
  );

  typedef struct {
    logic [1:0]  typ;
    logic [7:0]  addr, data, a, b, fun;
    logic        pe, pt;
    int          nb;
    logic [31:0] bytes;     // byte j at [8j+7:8j]
    logic [3:0]  pars;      // expected parity bit of byte j
    int          exp_done;  // cycle of the done pulse after the accept edge
  } vec_t;

  vec_t tbl [7];
  int checks   = 0;
  int failures = 0;

  function automatic vec_t mk(input logic [1:0] typ, input logic [7:0] addr,
      input logic [7:0] data, input logic [7:0] a, input logic [7:0] b,
      input logic [7:0] fun, input logic pe, input logic pt, input int nb,
      input logic [31:0] bytes, input logic [3:0] pars, input int exp_done);
    vec_t v;
    v.typ = typ; v.addr = addr; v.data = data; v.a = a; v.b = b; v.fun = fun;
    v.pe = pe; v.pt = pt; v.nb = nb; v.bytes = bytes; v.pars = pars;
    v.exp_done = exp_done;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.cmd_valid = 1'b1;
    bus.cmd_type  = v.typ;
    bus.cmd_addr  = v.addr;
    bus.cmd_data  = v.data;
    bus.cmd_op_a  = v.a;
    bus.cmd_op_b  = v.b;
    bus.cmd_fun   = v.fun;
    bus.par_en    = v.pe;
    bus.par_type  = v.pt;
  endtask

  // mode 0: drop valid after accept; 1: keep valid and present nxt;
  // 2: drop valid and toggle par_en/addr/data every cycle.
  task automatic run(input vec_t v, input int mode, input vec_t nxt, input string tag);
    int s, j, o, slot, sub;
    int line_err, rdy_err, done_err;
    logic [7:0] cur;
    logic exp_l, exp_rdy;
    logic [7:0] got [4];
    logic gp [4];
    line_err = 0; rdy_err = 0; done_err = 0;
    for (int i = 0; i < 4; i++) begin got[i] = 8'h00; gp[i] = 1'b0; end
    s = v.exp_done / v.nb;
    @(posedge clk);  // accept edge
    for (int k = 1; k <= v.exp_done; k++) begin
      @(negedge clk);
      j    = (k - 1) / s;
      o    = (k - 1) % s;
      slot = o / CPB;
      sub  = o % CPB;
      cur  = v.bytes[j*8 +: 8];
      if (slot == 0)                 exp_l = 1'b0;
      else if (slot <= 8)            exp_l = cur[slot-1];
      else if (slot == 9 && v.pe)    exp_l = v.pars[j];
      else                           exp_l = 1'b1;
      if (tx !== exp_l) line_err++;
      if (sub == CPB / 2) begin
        if (slot >= 1 && slot <= 8) got[j][slot-1] = tx;
        if (slot == 9) gp[j] = tx;
      end
      exp_rdy = (k == v.exp_done);
      if (bus.cmd_ready !== exp_rdy || busy !== ~exp_rdy) rdy_err++;
      if (done !== exp_rdy) done_err++;
      if (mode == 1) begin
        if (k == 1) drive(nxt);
      end else begin
        bus.cmd_valid = 1'b0;
        if (mode == 2) begin
          bus.par_en   = ~bus.par_en;
          bus.cmd_addr = ~bus.cmd_addr;
          bus.cmd_data = ~bus.cmd_data;
        end
      end
    end
    for (int i = 0; i < v.nb; i++) begin
      check($sformatf("%s_byte%0d", tag, i), {24'h0, got[i]}, {24'h0, v.bytes[i*8 +: 8]});
      if (v.pe) check($sformatf("%s_par%0d", tag, i), {31'h0, gp[i]}, {31'h0, v.pars[i]});
    end
    check($sformatf("%s_line_errs", tag), line_err, 0);
    check($sformatf("%s_ready_errs", tag), rdy_err, 0);
    check($sformatf("%s_done_errs", tag), done_err, 0);
  endtask

  initial begin
    int bad;
    tbl[0] = mk(2'd0, 8'h05, 8'h3C, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 3, 32'h003C05AA, 4'b0000, 264);
    tbl[1] = mk(2'd3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h07, 1'b1, 1'b0, 2, 32'h000007DD, 4'b0010, 192);
    tbl[2] = mk(2'd3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h07, 1'b1, 1'b1, 2, 32'h000007DD, 4'b0001, 192);
    tbl[3] = mk(2'd1, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 2, 32'h00005ABB, 4'b0011, 192);
    tbl[4] = mk(2'd2, 8'h00, 8'h00, 8'h12, 8'h34, 8'h00, 1'b0, 1'b0, 4, 32'h003412CC, 4'b0000, 352);
    tbl[5] = mk(2'd1, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 2, 32'h000002BB, 4'b0000, 176);
    tbl[6] = mk(2'd0, 8'h05, 8'h07, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 3, 32'h000705AA, 4'b0011, 288);

    bus.cmd_valid = 1'b0; bus.cmd_type = 2'd0; bus.cmd_addr = 8'h00;
    bus.cmd_data = 8'h00; bus.cmd_op_a = 8'h00; bus.cmd_op_b = 8'h00;
    bus.cmd_fun = 8'h00; bus.par_en = 1'b0; bus.par_type = 1'b0;

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_tx", {31'h0, tx}, 32'd1);
    check("rst_ready", {31'h0, bus.cmd_ready}, 32'd1);
    check("rst_busy", {31'h0, busy}, 32'd0);
    check("rst_done", {31'h0, done}, 32'd0);
    rst = 1'b0;

    // Idle for 50 cycles.
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (tx !== 1'b1 || bus.cmd_ready !== 1'b1 || done !== 1'b0) bad++;
    end
    check("idle_errs", bad, 0);

    // Table of single commands.
    for (int i = 0; i < 4; i++) begin
      drive(tbl[i]);
      run(tbl[i], 0, tbl[i], $sformatf("vec%0d", i));
    end

    // Valid held high: ALU command, then a read chained on the done edge.
    drive(tbl[4]);
    run(tbl[4], 1, tbl[5], "chain_alu");
    run(tbl[5], 0, tbl[5], "chain_rd");

    // Inputs toggled every cycle after accept must not affect the frame.
    drive(tbl[6]);
    run(tbl[6], 2, tbl[6], "toggle");

    // Reset during DATA bit 3 of the second byte (cycle 124, line low).
    drive(tbl[0]);
    @(posedge clk);
    for (int k = 1; k <= 124; k++) begin
      @(negedge clk);
      bus.cmd_valid = 1'b0;
    end
    check("abort_pre_line", {31'h0, tx}, 32'd0);
    #1 rst = 1'b1;
    #1;
    check("abort_tx", {31'h0, tx}, 32'd1);
    check("abort_ready", {31'h0, bus.cmd_ready}, 32'd1);
    check("abort_done", {31'h0, done}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (done !== 1'b0 || tx !== 1'b1 || bus.cmd_ready !== 1'b1) bad++;
    end
    check("abort_quiet_errs", bad, 0);
    drive(tbl[3]);
    run(tbl[3], 0, tbl[3], "post_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
